// File: rtl/fsm_job_initiator.sv
// Job initiator for a start/busy/complete worker: launch, timeout, retry, fault latch.
// Optional 1-deep request queue enabled by defining JOB_INIT_PENDING_EN.
module fsm_job_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_request,
    input  logic             i_clear,
    output logic             o_start,
    input  logic             i_busy,
    input  logic             i_complete,
    output logic             o_active,
    output logic             o_done,
    output logic             o_error,
    output logic [3:0]       o_retries,
    output logic [CNT_W-1:0] o_job_count,
    output logic             o_pending
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FINISH,
        S_FAULT
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         retries_q, retries_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pending_q, pending_d;
    logic               timeout;

    // i_complete wins over a timeout landing on the same cycle
    assign timeout = (timer_q == TIMER_LAST) && !i_complete;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retries_d = retries_q;
        count_d   = count_q;
        pending_d = pending_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_request || pending_q) begin
                    state_d   = S_LAUNCH;
                    retries_d = '0;
                    pending_d = 1'b0;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK, S_WAIT_DONE: begin
                timer_d = timer_q + 1'b1;
                if (i_complete) begin
                    state_d = S_FINISH;
                    count_d = count_q + 1'b1;
                end else if (timeout) begin
                    if (retries_q < RETRY_LIMIT) begin
                        retries_d = retries_q + 1'b1;
                        state_d   = S_LAUNCH;
                    end else begin
                        state_d = S_FAULT;
                    end
                end else if (state_q == S_WAIT_ACK && i_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_FINISH: begin
                if (pending_q) begin
                    state_d   = S_LAUNCH;
                    retries_d = '0;
                    pending_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                if (i_clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef JOB_INIT_PENDING_EN
        if (i_request && (state_q inside {S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE, S_FINISH})) begin
            pending_d = 1'b1;
        end
        if (state_d == S_FAULT) begin
            pending_d = 1'b0;
        end
`else
        pending_d = 1'b0;
`endif
    end

    // Outputs are registered from the next state so they line up with the state they decode
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            retries_q <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            o_start   <= 1'b0;
            o_active  <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retries_q <= retries_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            o_start   <= (state_d == S_LAUNCH);
            o_active  <= (state_d inside {S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE});
            o_done    <= (state_d == S_FINISH);
            o_error   <= (state_d == S_FAULT);
        end
    end

    assign o_retries   = retries_q;
    assign o_job_count = count_q;
    assign o_pending   = pending_q;

endmodule

// File: tb/tb_fsm_job_initiator.sv
// Directed self-checking bench for fsm_job_initiator (TIMEOUT_CYCLES=8, MAX_RETRIES=2, CNT_W=2).
module tb_fsm_job_initiator;

    logic       clk = 1'b0;
    logic       reset, request, clear, busy, complete;
    logic       start, active, done, error, pending;
    logic [3:0] retries;
    logic [1:0] job_count;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_count = 2'd0;

    always #5 clk = ~clk;

    fsm_job_initiator #(
        .TIMEOUT_CYCLES(8),
        .MAX_RETRIES   (2),
        .CNT_W         (2)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_request  (request),
        .i_clear    (clear),
        .o_start    (start),
        .i_busy     (busy),
        .i_complete (complete),
        .o_active   (active),
        .o_done     (done),
        .o_error    (error),
        .o_retries  (retries),
        .o_job_count(job_count),
        .o_pending  (pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; request = 1'b0; clear = 1'b0; busy = 1'b0; complete = 1'b0;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({start, active, done, error, pending} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {start, active, done, error, pending});
        end
        checks++;
        if (retries !== 4'd0) begin errors++; $display("FAIL reset_retries got %0d exp 0", retries); end
        checks++;
        if (job_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", job_count); end
    endtask

    task automatic test_single_job();
        int starts = 0, dones = 0, start_k = -1, done_k = -1;
        request = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (start) begin starts++; start_k = k; end
            if (done) begin dones++; done_k = k; end
            request  = 1'b0;
            busy     = (k >= 2 && k <= 6);
            complete = (k == 7);
        end
        exp_count++;
        checks++;
        if (starts !== 1 || start_k !== 1) begin
            errors++; $display("FAIL single_start got n=%0d at %0d exp n=1 at 1", starts, start_k);
        end
        checks++;
        if (dones !== 1 || done_k !== 8) begin
            errors++; $display("FAIL single_done got n=%0d at %0d exp n=1 at 8", dones, done_k);
        end
        checks++;
        if (job_count !== exp_count) begin
            errors++; $display("FAIL single_count got %0d exp %0d", job_count, exp_count);
        end
        checks++;
        if (retries !== 4'd0 || active !== 1'b0) begin
            errors++; $display("FAIL single_idle got retries=%0d active=%b exp 0 0", retries, active);
        end
    endtask

    task automatic test_timeout_fault();
        int starts = 0, dones = 0;
        int sk[3] = '{-1, -1, -1};
        request = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (start) begin
                if (starts < 3) sk[starts] = k;
                starts++;
            end
            if (done) dones++;
            // requests while faulted (from k=28) must be dropped
            request = (k >= 29 && k <= 30);
        end
        // LAUNCH + 8 WAIT_ACK cycles per attempt -> starts 9 cycles apart
        checks++;
        if (starts !== 3 || sk[0] !== 1 || sk[1] !== 10 || sk[2] !== 19) begin
            errors++;
            $display("FAIL timeout_starts got n=%0d at %0d,%0d,%0d exp n=3 at 1,10,19",
                     starts, sk[0], sk[1], sk[2]);
        end
        checks++;
        if (error !== 1'b1 || active !== 1'b0) begin
            errors++; $display("FAIL fault_state got error=%b active=%b exp 1 0", error, active);
        end
        checks++;
        if (retries !== 4'd2) begin errors++; $display("FAIL fault_retries got %0d exp 2", retries); end
        checks++;
        if (job_count !== exp_count || dones !== 0) begin
            errors++; $display("FAIL fault_count got %0d dones=%0d exp %0d dones=0", job_count, dones, exp_count);
        end
        request = 1'b0;
        clear   = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (error !== 1'b0 || active !== 1'b0) begin
            errors++; $display("FAIL clear got error=%b active=%b exp 0 0", error, active);
        end
        step();
        checks++;
        if (start !== 1'b0 || active !== 1'b0) begin
            errors++; $display("FAIL fault_drop got start=%b active=%b exp 0 0", start, active);
        end
    endtask

    task automatic test_retry_success();
        int starts = 0, dones = 0, done_k = -1;
        request = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (start) starts++;
            if (done) begin dones++; done_k = k; end
            request  = 1'b0;
            complete = (k == 12);
        end
        exp_count++;
        checks++;
        if (starts !== 2 || dones !== 1 || done_k !== 13) begin
            errors++; $display("FAIL retry_ok got starts=%0d dones=%0d at %0d exp 2 1 at 13", starts, dones, done_k);
        end
        checks++;
        if (retries !== 4'd1) begin errors++; $display("FAIL retry_ok_retries got %0d exp 1", retries); end
        checks++;
        if (job_count !== exp_count) begin
            errors++; $display("FAIL retry_ok_count got %0d exp %0d", job_count, exp_count);
        end
    endtask

    task automatic test_timeout_tie();
        int starts = 0, dones = 0, done_k = -1;
        request = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (start) starts++;
            if (done) begin dones++; done_k = k; end
            request  = 1'b0;
            busy     = (k >= 2 && k <= 9);
            complete = (k == 9);
        end
        exp_count++;
        checks++;
        if (starts !== 1 || dones !== 1 || done_k !== 10) begin
            errors++; $display("FAIL tie got starts=%0d dones=%0d at %0d exp 1 1 at 10", starts, dones, done_k);
        end
        checks++;
        if (retries !== 4'd0 || job_count !== exp_count) begin
            errors++; $display("FAIL tie_state got retries=%0d count=%0d exp 0 %0d", retries, job_count, exp_count);
        end
    endtask

    task automatic test_count_wrap_and_reset();
        logic [1:0] seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_count = 2'd0;
        for (int j = 0; j < 5; j++) begin
            request = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                step();
                request  = 1'b0;
                complete = (k == 2);
            end
            exp_count++;
            checks++;
            if (job_count !== seq[j]) begin
                errors++; $display("FAIL wrap_count job %0d got %0d exp %0d", j, job_count, seq[j]);
            end
        end
        request = 1'b1;
        step();
        request = 1'b0;
        busy    = 1'b1;
        step();
        step();
        checks++;
        if (active !== 1'b1) begin errors++; $display("FAIL wait_done_active got %b exp 1", active); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        busy  = 1'b0;
        exp_count = 2'd0;
        checks++;
        if ({start, active, done, error, pending, retries, job_count} !== 11'b0) begin
            errors++;
            $display("FAIL midjob_reset got %b exp 0",
                     {start, active, done, error, pending, retries, job_count});
        end
        complete = 1'b1;
        step();
        complete = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || job_count !== 2'd0) begin
            errors++; $display("FAIL abandoned got done=%b count=%0d exp 0 0", done, job_count);
        end
    endtask

    task automatic test_request_in_wait_done();
        int starts = 0, dones = 0;
        logic pend5 = 1'b0, start8 = 1'b0, active8 = 1'b0, pend9 = 1'b1;
        request = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (start) starts++;
            if (done) dones++;
            if (k == 5) pend5 = pending;
            if (k == 8) begin start8 = start; active8 = active; end
            if (k == 9) pend9 = pending;
            request  = (k == 4);
            busy     = (k >= 2 && k <= 5);
            complete = (k == 6 || k == 10);
        end
`ifdef JOB_INIT_PENDING_EN
        exp_count = exp_count + 2'd2;
        checks++;
        if (pend5 !== 1'b1 || pend9 !== 1'b0) begin
            errors++; $display("FAIL queue_flag got k5=%b k9=%b exp 1 0", pend5, pend9);
        end
        checks++;
        if (start8 !== 1'b1 || active8 !== 1'b1) begin
            errors++; $display("FAIL queue_relaunch got start=%b active=%b exp 1 1", start8, active8);
        end
        checks++;
        if (starts !== 2 || dones !== 2) begin
            errors++; $display("FAIL queue_jobs got starts=%0d dones=%0d exp 2 2", starts, dones);
        end
`else
        exp_count = exp_count + 2'd1;
        checks++;
        if (pend5 !== 1'b0 || pend9 !== 1'b0) begin
            errors++; $display("FAIL no_queue_flag got k5=%b k9=%b exp 0 0", pend5, pend9);
        end
        checks++;
        if (start8 !== 1'b0 || active8 !== 1'b0) begin
            errors++; $display("FAIL no_queue_idle got start=%b active=%b exp 0 0", start8, active8);
        end
        checks++;
        if (starts !== 1 || dones !== 1) begin
            errors++; $display("FAIL no_queue_jobs got starts=%0d dones=%0d exp 1 1", starts, dones);
        end
`endif
        checks++;
        if (job_count !== exp_count || active !== 1'b0) begin
            errors++; $display("FAIL req_wait_end got count=%0d active=%b exp %0d 0", job_count, active, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_timeout_fault();
        test_retry_success();
        test_timeout_tie();
        test_count_wrap_and_reset();
        test_request_in_wait_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
